video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter CE_DIV, default 4: clk cycles per pixel; legal range 1..16.
REQ-002 Parameter H_ACTIVE, default 384: visible pixels per line.
REQ-003 Parameters H_FP / H_SYNC / H_BP, defaults 8 / 32 / 88: horizontal porches and sync width, in pixels; H_TOTAL = sum of all four = 512.
REQ-004 Parameter V_ACTIVE, default 256: visible lines per frame.
REQ-005 Parameters V_FP / V_SYNC / V_BP, defaults 8 / 4 / 16: vertical porches and sync width, in lines; V_TOTAL = 284.
REQ-006 clk  input  1  sole clock; all state changes on the rising edge.
REQ-007 reset  input  1  asynchronous, active-high.
REQ-008 pixel_ce  output  1  pixel-rate enable, one clk wide.
REQ-009 HS, VS  output  1 each  sync pulses, active-high.
REQ-010 HBLANK, VBLANK  output  1 each  blanking flags, active-high.
REQ-011 hpos, vpos  output  10 each  current pixel column and line.
REQ-012 frame_start  output  1  one-clk pulse at the start of pixel (0,0).
REQ-013 RGB_R, RGB_G, RGB_B  output  8 each  test-pattern colour.

Function
REQ-014 Divider counter counts 0..CE_DIV-1 and wraps; pixel_ce is registered and high for the single clk where the divider equals CE_DIV-1.
REQ-015 CE_DIV=1: pixel_ce is high on every clk after reset is released.
REQ-016 hcnt advances by 1 only on pixel_ce and wraps from H_TOTAL-1 to 0.
REQ-017 vcnt advances by 1 only when hcnt wraps, and wraps from V_TOTAL-1 to 0.
REQ-018 hpos = hcnt and vpos = vcnt; both are registered and update on the clk edge where pixel_ce is sampled high.
REQ-019 HBLANK = (hcnt >= H_ACTIVE).
REQ-020 HS = (H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC).
REQ-021 VBLANK = (vcnt >= V_ACTIVE).
REQ-022 VS = (V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC).
REQ-023 VS and VBLANK change only on the edge where hcnt wraps to 0.
REQ-024 All timing outputs (HS, VS, HBLANK, VBLANK, hpos, vpos) are registered and change on the same clk edge, so no output is skewed against another.
REQ-025 frame_start is high for exactly one clk: the clk following the edge where hcnt and vcnt both become 0.
REQ-026 Counter widths are 10 bits; parameters with H_TOTAL > 1024 or V_TOTAL > 1024 are illegal and flagged by a simulation-time assertion.

Reset
REQ-027 While reset is high, all of the following are 0: divider, hcnt, vcnt, pixel_ce, HS, VS, HBLANK, VBLANK, hpos, vpos, frame_start, RGB_R, RGB_G, RGB_B.
REQ-028 After reset deasserts, the first pixel_ce occurs CE_DIV clks later, and the frame begins at (0,0) in the active region.
REQ-029 Reset asserted mid-frame aborts the frame immediately (asynchronously); no partial sync pulse is extended.

Configuration
REQ-030 Macro TEST_PATTERN_EN defined: RGB outputs drive 8 vertical bars, each H_ACTIVE/8 pixels wide (48 at default). Left to right: white, yellow, cyan, green, magenta, red, blue, black. Each component is FF or 00. All RGB outputs are 00 while HBLANK or VBLANK is high. RGB is registered in the same stage as hpos.
REQ-031 Macro TEST_PATTERN_EN undefined: RGB_R/G/B are constant 0 and no pattern logic is synthesised.

Verification
REQ-032 Release reset with defaults -> first pixel_ce at clk 4; pixel_ce then repeats every 4 clks, each pulse 1 clk wide.
REQ-033 Run one full line -> HBLANK rises at hpos=384; HS is high for hpos 392..423 (32 pixels); hpos wraps from 511 to 0.
REQ-034 Run one full frame -> VBLANK high for vpos 256..283; VS high for vpos 264..267; VS edges coincide with hpos=0; frame_start pulses once per 512*284*4 = 581632 clks.
REQ-035 Assert reset at hpos=400, vpos=265, mid HS/VS -> all outputs 0 within the same cycle (asynchronous); after release, counting restarts at (0,0).
REQ-036 CE_DIV=1 -> pixel_ce stays high continuously; one line lasts exactly 512 clks.
REQ-037 TEST_PATTERN_EN defined, hpos=50, vpos=10 -> RGB = FF,FF,00 (yellow). At hpos=400 -> RGB = 00,00,00. TEST_PATTERN_EN undefined -> RGB is 0 throughout.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-rate enable, H/V counters, sync, blanking.
// Define TEST_PATTERN_EN to drive 8 colour bars on RGB; otherwise RGB is 0.
module video_timing_gen #(
    parameter int CE_DIV   = 4,
    parameter int H_ACTIVE = 384,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 256,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 16
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_ce,
    output logic       HS,
    output logic       VS,
    output logic       HBLANK,
    output logic       VBLANK,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       frame_start,
    output logic [7:0] RGB_R,
    output logic [7:0] RGB_G,
    output logic [7:0] RGB_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]  DIV_MAX = 4'(CE_DIV - 1);
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0] div_q, div_d;
    logic       pce_q, pce_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       hb_q, hb_d;
    logic       vb_q, vb_d;
    logic       fs_q, fs_d;

    // Flags are decoded from the next counter values so they share one edge
    always_comb begin
        div_d  = (div_q == DIV_MAX) ? 4'd0 : div_q + 4'd1;
        pce_d  = (div_q == DIV_MAX);
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        fs_d   = 1'b0;
        if (pce_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = 10'd0;
                vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
                fs_d   = (vcnt_q == V_LAST);
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end
        hb_d = ({1'b0, hcnt_d} >= H_ACT);
        hs_d = ({1'b0, hcnt_d} >= HS_BEG) && ({1'b0, hcnt_d} < HS_END);
        vb_d = ({1'b0, vcnt_d} >= V_ACT);
        vs_d = ({1'b0, vcnt_d} >= VS_BEG) && ({1'b0, vcnt_d} < VS_END);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= 4'd0;
            pce_q  <= 1'b0;
            hcnt_q <= 10'd0;
            vcnt_q <= 10'd0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            hb_q   <= 1'b0;
            vb_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            pce_q  <= pce_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            hb_q   <= hb_d;
            vb_q   <= vb_d;
            fs_q   <= fs_d;
        end
    end

    assign pixel_ce    = pce_q;
    assign HS          = hs_q;
    assign VS          = vs_q;
    assign HBLANK      = hb_q;
    assign VBLANK      = vb_q;
    assign hpos        = hcnt_q;
    assign vpos        = vcnt_q;
    assign frame_start = fs_q;

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [9:0] bar_full;
    logic [2:0] bar;
    logic       blank_d;
    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;
    logic [7:0] b_q, b_d;

    // Bar index bits map directly to colour: bit2 kills G, bit1 R, bit0 B
    always_comb begin
        bar_full = hcnt_d / 10'(BAR_W);
        bar      = (bar_full > 10'd7) ? 3'd7 : bar_full[2:0];
        blank_d  = hb_d | vb_d;
        r_d      = (blank_d || bar[1]) ? 8'h00 : 8'hFF;
        g_d      = (blank_d || bar[2]) ? 8'h00 : 8'hFF;
        b_d      = (blank_d || bar[0]) ? 8'h00 : 8'hFF;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= 8'h00;
            g_q <= 8'h00;
            b_q <= 8'h00;
        end else begin
            r_q <= r_d;
            g_q <= g_d;
            b_q <= b_d;
        end
    end

    assign RGB_R = r_q;
    assign RGB_G = g_q;
    assign RGB_B = b_q;
`else
    assign RGB_R = 8'h00;
    assign RGB_G = 8'h00;
    assign RGB_B = 8'h00;
`endif

    always @(posedge clk) begin
        assert (H_TOTAL <= 1024 && V_TOTAL <= 1024 &&
                CE_DIV >= 1 && CE_DIV <= 16)
            else $error("video_timing_gen: illegal timing parameters");
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three parameterisations checked against a
// closed-form raster model derived from elapsed clocks since reset release.
module tb_video_timing_gen;

    typedef struct packed {
        logic       pce;
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
        logic [9:0] h;
        logic [9:0] v;
        logic       fs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vt_t;

    localparam logic [23:0] PAL [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   t_a = 0;
    int   t_b = 0;
    int   t_c = 0;

    always #5 clk = ~clk;

    logic       a_pce, a_hs, a_vs, a_hb, a_vb, a_fs;
    logic [9:0] a_h, a_v;
    logic [7:0] a_r, a_g, a_b;
    logic       b_pce, b_hs, b_vs, b_hb, b_vb, b_fs;
    logic [9:0] b_h, b_v;
    logic [7:0] b_r, b_g, b_b;
    logic       c_pce, c_hs, c_vs, c_hb, c_vb, c_fs;
    logic [9:0] c_h, c_v;
    logic [7:0] c_r, c_g, c_b;

    vt_t obs_a, obs_b, obs_c;
    assign obs_a = {a_pce, a_hs, a_vs, a_hb, a_vb, a_h, a_v, a_fs, a_r, a_g, a_b};
    assign obs_b = {b_pce, b_hs, b_vs, b_hb, b_vb, b_h, b_v, b_fs, b_r, b_g, b_b};
    assign obs_c = {c_pce, c_hs, c_vs, c_hb, c_vb, c_h, c_v, c_fs, c_r, c_g, c_b};

    video_timing_gen dut_a (
        .clk(clk), .reset(rst_a), .pixel_ce(a_pce), .HS(a_hs), .VS(a_vs),
        .HBLANK(a_hb), .VBLANK(a_vb), .hpos(a_h), .vpos(a_v),
        .frame_start(a_fs), .RGB_R(a_r), .RGB_G(a_g), .RGB_B(a_b));

    video_timing_gen #(
        .CE_DIV(1), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .clk(clk), .reset(rst_b), .pixel_ce(b_pce), .HS(b_hs), .VS(b_vs),
        .HBLANK(b_hb), .VBLANK(b_vb), .hpos(b_h), .vpos(b_v),
        .frame_start(b_fs), .RGB_R(b_r), .RGB_G(b_g), .RGB_B(b_b));

    video_timing_gen #(
        .CE_DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2)
    ) dut_c (
        .clk(clk), .reset(rst_c), .pixel_ce(c_pce), .HS(c_hs), .VS(c_vs),
        .HBLANK(c_hb), .VBLANK(c_vb), .hpos(c_h), .vpos(c_v),
        .frame_start(c_fs), .RGB_R(c_r), .RGB_G(c_g), .RGB_B(c_b));

    always @(posedge clk or posedge rst_a) t_a <= rst_a ? 0 : t_a + 1;
    always @(posedge clk or posedge rst_b) t_b <= rst_b ? 0 : t_b + 1;
    always @(posedge clk or posedge rst_c) t_c <= rst_c ? 0 : t_c + 1;

    // Expected outputs t rising edges after reset release
    function automatic vt_t model(input int t, input int ce,
                                  input int ha, input int hf, input int hw, input int hbp,
                                  input int va, input int vf, input int vw, input int vbp);
        vt_t e;
        int  ht, vt, n, h, v;
        e = '0;
        if (t == 0) return e;
        ht = ha + hf + hw + hbp;
        vt = va + vf + vw + vbp;
        n = (t - 1) / ce;
        h = n % ht;
        v = (n / ht) % vt;
        e.pce = (t % ce == 0);
        e.hb = (h >= ha);
        e.hs = (h >= ha + hf) && (h < ha + hf + hw);
        e.vb = (v >= va);
        e.vs = (v >= va + vf) && (v < va + vf + vw);
        e.h = 10'(h);
        e.v = 10'(v);
        e.fs = (n > 0) && ((t - 1) % ce == 0) && (h == 0) && (v == 0);
`ifdef TEST_PATTERN_EN
        if (!e.hb && !e.vb) begin
            int bar;
            bar = h / (ha / 8);
            if (bar > 7) bar = 7;
            {e.r, e.g, e.b} = PAL[bar];
        end
`endif
        return e;
    endfunction

    function automatic vt_t exp_a(input int t);
        return model(t, 4, 384, 8, 32, 88, 256, 8, 4, 16);
    endfunction

    function automatic vt_t exp_b(input int t);
        return model(t, 1, 384, 8, 32, 88, 6, 1, 2, 1);
    endfunction

    function automatic vt_t exp_c(input int t);
        return model(t, 3, 16, 2, 3, 3, 4, 1, 1, 2);
    endfunction

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs_a !== '0) begin
            errors++; $display("FAIL reset_a got %h exp 0", obs_a);
        end
        checks++;
        if (obs_b !== '0) begin
            errors++; $display("FAIL reset_b got %h exp 0", obs_b);
        end
        checks++;
        if (obs_c !== '0) begin
            errors++; $display("FAIL reset_c got %h exp 0", obs_c);
        end
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    endtask

    task automatic test_pixel_ce();
        int first;
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (a_pce === 1'b1) begin first = k; break; end
        end
        checks++;
        if (first != 4) begin
            errors++; $display("FAIL pce_first got %0d exp 4", first);
        end
        for (int k = 5; k <= 28; k++) begin
            @(posedge clk); #1;
            checks++;
            if (a_pce !== (k % 4 == 0)) begin
                errors++; $display("FAIL pce_period edge %0d got %b", k, a_pce);
            end
            checks++;
            if (b_pce !== 1'b1) begin
                errors++; $display("FAIL pce_div1 edge %0d got %b exp 1", k, b_pce);
            end
        end
    endtask

    task automatic test_line();
        int   n;
        logic p_hb, p_hs;
        logic [9:0] p_h;
        bit   s_hb, s_hsr, s_hsf, s_wrap;
        vt_t  e;
        n = 2 * 2048 + int'($urandom_range(0, 300));
        p_hb = a_hb; p_hs = a_hs; p_h = a_h;
        s_hb = 0; s_hsr = 0; s_hsf = 0; s_wrap = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            e = exp_a(t_a);
            checks++;
            if (obs_a !== e) begin
                errors++; $display("FAIL line_model t=%0d got %h exp %h", t_a, obs_a, e);
            end
            if (a_hb && !p_hb && !s_hb) begin
                s_hb = 1; checks++;
                if (a_h !== 10'd384) begin
                    errors++; $display("FAIL hblank_rise got %0d exp 384", a_h);
                end
            end
            if (a_hs && !p_hs && !s_hsr) begin
                s_hsr = 1; checks++;
                if (a_h !== 10'd392) begin
                    errors++; $display("FAIL hs_first got %0d exp 392", a_h);
                end
            end
            if (!a_hs && p_hs && !s_hsf) begin
                s_hsf = 1; checks++;
                if (p_h !== 10'd423) begin
                    errors++; $display("FAIL hs_last got %0d exp 423", p_h);
                end
            end
            if (a_h == 10'd0 && p_h != 10'd0 && !s_wrap) begin
                s_wrap = 1; checks++;
                if (p_h !== 10'd511) begin
                    errors++; $display("FAIL hwrap got %0d exp 511", p_h);
                end
            end
            p_hb = a_hb; p_hs = a_hs; p_h = a_h;
        end
        checks++;
        if (!(s_hb && s_hsr && s_hsf && s_wrap)) begin
            errors++;
            $display("FAIL line_events got %b%b%b%b exp 1111", s_hb, s_hsr, s_hsf, s_wrap);
        end
    endtask

    task automatic test_pattern();
        bit  hit;
        vt_t e;
        logic [23:0] want;
        hit = 0;
        for (int k = 0; k < 25000; k++) begin
            @(posedge clk); #1;
            e = exp_a(t_a);
            checks++;
            if (obs_a !== e) begin
                errors++; $display("FAIL pat_model t=%0d got %h exp %h", t_a, obs_a, e);
            end
            if (a_h == 10'd50 && a_v == 10'd10) begin hit = 1; break; end
        end
`ifdef TEST_PATTERN_EN
        want = 24'hFFFF00;
`else
        want = 24'h000000;
`endif
        checks++;
        if (!hit || {a_r, a_g, a_b} !== want) begin
            errors++; $display("FAIL pat_yellow hit=%0d got %h exp %h", hit, {a_r, a_g, a_b}, want);
        end
        hit = 0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (a_h == 10'd400) begin hit = 1; break; end
        end
        checks++;
        if (!hit || {a_r, a_g, a_b} !== 24'h0) begin
            errors++; $display("FAIL pat_blank hit=%0d got %h exp 0", hit, {a_r, a_g, a_b});
        end
    endtask

    task automatic test_frame();
        int   nfs, last_fs, last_wrap, nwrap;
        int   vb_min, vb_max, vs_min, vs_max;
        logic p_vs;
        logic [9:0] p_h;
        vt_t  e;
        nfs = 0; last_fs = -1; last_wrap = -1; nwrap = 0;
        vb_min = 1000; vb_max = -1; vs_min = 1000; vs_max = -1;
        p_vs = b_vs; p_h = b_h;
        for (int k = 0; k < 12000 && nfs < 2; k++) begin
            @(posedge clk); #1;
            e = exp_b(t_b);
            checks++;
            if (obs_b !== e) begin
                errors++; $display("FAIL frame_model t=%0d got %h exp %h", t_b, obs_b, e);
            end
            if (b_fs) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (t_b - last_fs != 5120) begin
                        errors++; $display("FAIL fs_period got %0d exp 5120", t_b - last_fs);
                    end
                end
                last_fs = t_b; nfs++;
            end
            if (b_h == 10'd0 && p_h != 10'd0) begin
                if (last_wrap >= 0 && nwrap < 4) begin
                    checks++;
                    if (t_b - last_wrap != 512) begin
                        errors++; $display("FAIL line_len got %0d exp 512", t_b - last_wrap);
                    end
                end
                last_wrap = t_b; nwrap++;
            end
            if (b_vs !== p_vs) begin
                checks++;
                if (b_h !== 10'd0) begin
                    errors++; $display("FAIL vs_edge got hpos %0d exp 0", b_h);
                end
            end
            if (b_vb) begin
                if (int'(b_v) < vb_min) vb_min = int'(b_v);
                if (int'(b_v) > vb_max) vb_max = int'(b_v);
            end
            if (b_vs) begin
                if (int'(b_v) < vs_min) vs_min = int'(b_v);
                if (int'(b_v) > vs_max) vs_max = int'(b_v);
            end
            p_vs = b_vs; p_h = b_h;
        end
        checks++;
        if (nfs < 2) begin
            errors++; $display("FAIL fs_timeout got %0d pulses exp 2", nfs);
        end
        checks++;
        if (vb_min != 6 || vb_max != 9) begin
            errors++; $display("FAIL vblank_range got %0d..%0d exp 6..9", vb_min, vb_max);
        end
        checks++;
        if (vs_min != 7 || vs_max != 8) begin
            errors++; $display("FAIL vs_range got %0d..%0d exp 7..8", vs_min, vs_max);
        end
    endtask

    task automatic test_midframe_reset();
        bit  hit;
        vt_t e;
        hit = 0;
        for (int k = 0; k < 6000; k++) begin
            @(posedge clk); #1;
            e = exp_b(t_b);
            checks++;
            if (obs_b !== e) begin
                errors++; $display("FAIL mid_model t=%0d got %h exp %h", t_b, obs_b, e);
            end
            if (b_h == 10'd400 && b_v == 10'd7) begin hit = 1; break; end
        end
        checks++;
        if (!hit || b_hs !== 1'b1 || b_vs !== 1'b1) begin
            errors++; $display("FAIL mid_syncs hit=%0d got hs=%b vs=%b exp 11", hit, b_hs, b_vs);
        end
        #1 rst_b = 1'b1;
        #1;
        checks++;
        if (obs_b !== '0) begin
            errors++; $display("FAIL mid_async got %h exp 0", obs_b);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            e = exp_b(t_b);
            checks++;
            if (obs_b !== e || (k == 0 && (b_h !== 10'd0 || b_v !== 10'd0))) begin
                errors++; $display("FAIL mid_restart t=%0d got %h exp %h", t_b, obs_b, e);
            end
        end
    endtask

    task automatic test_random_resets();
        int  n;
        vt_t e;
        for (int it = 0; it < 6; it++) begin
            n = int'($urandom_range(1, 1500));
            for (int k = 0; k < n; k++) begin
                @(posedge clk); #1;
                e = exp_c(t_c);
                checks++;
                if (obs_c !== e) begin
                    errors++; $display("FAIL rand_model it=%0d t=%0d got %h exp %h", it, t_c, obs_c, e);
                end
            end
            #1 rst_c = 1'b1;
            #1;
            checks++;
            if (obs_c !== '0) begin
                errors++; $display("FAIL rand_async it=%0d got %h exp 0", it, obs_c);
            end
            repeat (int'($urandom_range(1, 3))) @(posedge clk);
            @(negedge clk);
            rst_c = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_pixel_ce();
        test_line();
        test_pattern();
        test_frame();
        test_midframe_reset();
        test_random_resets();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
